// File: rtl/dda_cfg_loader_pkg.sv
// Shared types and constants for the Lorenz DDA configuration loader.
// Sizes that depend on the posit width are provided as functions of N.
package dda_cfg_loader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_INIT = 2'd2,
      ST_RUN  = 2'd3
   } state_e;

   localparam int NUM_WORDS = 7;

   localparam int IDX_ICX   = 0;
   localparam int IDX_ICY   = 1;
   localparam int IDX_ICZ   = 2;
   localparam int IDX_SIGMA = 3;
   localparam int IDX_BETA  = 4;
   localparam int IDX_RHO   = 5;
   localparam int IDX_DT    = 6;

   function automatic int num_cfg_bytes(input int n);
      return NUM_WORDS * (n / 8);
   endfunction

   // Wide enough to hold the full byte count, not just the last index.
   function automatic int byte_cnt_width(input int n);
      return $clog2(NUM_WORDS * (n / 8) + 1);
   endfunction

endpackage

// File: rtl/dda_cfg_loader_step_prescaler.sv
// Integration step strobe generator: one dda_en pulse every div_q+1 RUN cycles,
// with a modular count of the pulses issued.
module dda_step_prescaler #(
   parameter int STEP_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              div_load_i,
   input  logic [7:0]        div_i,
   input  logic              clr_i,
   input  logic              active_i,
   output logic              stb_o,
   output logic [STEP_W-1:0] step_count_o
);

   logic [7:0]        div_q, div_d;
   logic [7:0]        presc_q, presc_d;
   logic [STEP_W-1:0] cnt_q, cnt_d;

   assign stb_o        = active_i && (presc_q == div_q);
   assign step_count_o = cnt_q;

   always_comb begin
      div_d   = div_q;
      presc_d = presc_q;
      cnt_d   = cnt_q;
      if (div_load_i) begin
         div_d = div_i;
      end
      if (clr_i) begin
         presc_d = '0;
         cnt_d   = '0;
      end else if (active_i) begin
         if (presc_q == div_q) begin
            presc_d = '0;
            cnt_d   = cnt_q + 1'b1;
         end else begin
            presc_d = presc_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q   <= '0;
         presc_q <= '0;
         cnt_q   <= '0;
      end else begin
         div_q   <= div_d;
         presc_q <= presc_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/dda_cfg_loader.sv
// Byte-stream configuration loader and rst/en sequencer for the Lorenz posit DDA core.
// All outputs decode registered state only.
module dda_cfg_loader
   import dda_cfg_loader_pkg::*;
#(
   parameter int N      = 16,
   parameter int ES     = 1,
   parameter int STEP_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              run,
   input  logic              stop,
   input  logic [7:0]        data_in,
   input  logic              data_valid,
   input  logic [7:0]        div,
   output logic [N-1:0]      icx,
   output logic [N-1:0]      icy,
   output logic [N-1:0]      icz,
   output logic [N-1:0]      sigma,
   output logic [N-1:0]      beta,
   output logic [N-1:0]      rho,
   output logic [N-1:0]      dt,
   output logic              dda_rst,
   output logic              dda_en,
   output logic              cfg_valid,
   output logic              busy,
   output logic [STEP_W-1:0] step_count
);

   localparam int BPW = N / 8;
   localparam int NB  = num_cfg_bytes(N);
   localparam int BCW = byte_cnt_width(N);

   if ((N % 8) != 0 || N < 8 || ES < 0) begin : g_bad_param
      $error("dda_cfg_loader: N must be a positive multiple of 8 and ES non-negative");
   end

   state_e         state_q, state_d;
   logic [BCW-1:0] bcnt_q, bcnt_d;
   logic           cfg_valid_q, cfg_valid_d;
   logic           byte_wr;
   logic           run_acc;
   logic           step_stb;
   logic [N-1:0]   word_q [NUM_WORDS];

   always_comb begin
      state_d     = state_q;
      bcnt_d      = bcnt_q;
      cfg_valid_d = cfg_valid_q;
      byte_wr     = 1'b0;
      run_acc     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (stop) begin
               state_d = ST_IDLE;
            end else if (load) begin
               state_d     = ST_LOAD;
               bcnt_d      = '0;
               cfg_valid_d = 1'b0;
            end else if (run && cfg_valid_q) begin
               state_d = ST_INIT;
               run_acc = 1'b1;
            end
         end
         ST_LOAD: begin
            // An abort takes precedence over a byte arriving in the same cycle.
            if (stop) begin
               state_d = ST_IDLE;
            end else if (data_valid) begin
               byte_wr = 1'b1;
               bcnt_d  = bcnt_q + 1'b1;
               if (bcnt_q == BCW'(NB - 1)) begin
                  state_d     = ST_IDLE;
                  cfg_valid_d = 1'b1;
               end
            end
         end
         ST_INIT: state_d = stop ? ST_IDLE : ST_RUN;
         ST_RUN:  if (stop) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         bcnt_q      <= '0;
         cfg_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         bcnt_q      <= bcnt_d;
         cfg_valid_q <= cfg_valid_d;
      end
   end

   // Byte k of the stream lands in word k/BPW, most significant byte first.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int w = 0; w < NUM_WORDS; w++) begin
            word_q[w] <= '0;
         end
      end else if (byte_wr) begin
         for (int w = 0; w < NUM_WORDS; w++) begin
            for (int b = 0; b < BPW; b++) begin
               if (bcnt_q == BCW'(w * BPW + b)) begin
                  word_q[w][N-1-8*b -: 8] <= data_in;
               end
            end
         end
      end
   end

   dda_step_prescaler #(
      .STEP_W (STEP_W)
   ) u_presc (
      .clk          (clk),
      .rst          (rst),
      .div_load_i   (run_acc),
      .div_i        (div),
      .clr_i        (state_q == ST_INIT),
      .active_i     (state_q == ST_RUN),
      .stb_o        (step_stb),
      .step_count_o (step_count)
   );

   assign icx       = word_q[IDX_ICX];
   assign icy       = word_q[IDX_ICY];
   assign icz       = word_q[IDX_ICZ];
   assign sigma     = word_q[IDX_SIGMA];
   assign beta      = word_q[IDX_BETA];
   assign rho       = word_q[IDX_RHO];
   assign dt        = word_q[IDX_DT];
   assign cfg_valid = cfg_valid_q;
   assign busy      = (state_q != ST_IDLE);
   assign dda_rst   = (state_q == ST_INIT);
   // The INIT cycle also pulses en so the integrators capture their ICs.
   assign dda_en    = (state_q == ST_INIT) || step_stb;

endmodule

// File: doc/dda_cfg_loader.md
Name: dda_cfg_loader

Overview:
- Upstream control stage for the Lorenz posit DDA core.
- Accepts a byte-wide configuration stream carrying the 7 posit words icx, icy, icz, sigma, beta, rho and dt, and holds them as stable registers feeding the core.
- Sequences the core's rst/en pins: a one-cycle initial-condition load, then prescaled integration steps.
- Counts the number of integration steps issued.

Parameters:
- N, 16, posit word width; must be a multiple of 8.
- ES, 1, posit exponent size; passed through only, no arithmetic here.
- STEP_W, 16, width of the step counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- load  in  1  one-cycle command: start a configuration load.
- run  in  1  one-cycle command: start integration.
- stop  in  1  one-cycle command: abort a load, or halt a run.
- data_in  in  8  configuration byte.
- data_valid  in  1  data_in is valid this cycle.
- div  in  8  step prescaler; sampled on an accepted run.
- icx, icy, icz, sigma, beta, rho, dt  out  N each  registered posit words to the core.
- dda_rst  out  1  drives the core rst.
- dda_en  out  1  drives the core en.
- cfg_valid  out  1  a complete configuration is held.
- busy  out  1  state is not IDLE.
- step_count  out  STEP_W  number of dda_en pulses issued in RUN.

Behaviour:
- Reset is asynchronous, active-high. On reset:
  - state = IDLE.
  - All 7 words = 0.
  - cfg_valid = 0, dda_rst = 0, dda_en = 0, busy = 0.
  - step_count = 0, byte counter = 0, prescaler = 0, div_q = 0.
- Outputs are Moore-decoded from registered state/counters. There is no combinational path from any input to any output.
- Command priority within a cycle: stop > load > run. data_valid is ignored outside LOAD.
- IDLE:
  - load → LOAD next cycle; byte counter = 0; cfg_valid = 0.
  - run with cfg_valid = 1 → INIT next cycle; div_q = div.
  - run with cfg_valid = 0 is ignored.
  - stop has no effect.
- LOAD:
  - Each data_valid byte is written to the word at index bcnt / (N/8), at byte position MSB-first.
  - Word order: 0 icx, 1 icy, 2 icz, 3 sigma, 4 beta, 5 rho, 6 dt.
  - After byte number 7·N/8 (14 at N=16) is written: next state IDLE, cfg_valid = 1 in the following cycle.
  - stop → IDLE; cfg_valid stays 0; partially written words keep their new bytes.
  - load or run while in LOAD is ignored.
- INIT:
  - Lasts exactly one cycle, with dda_rst = 1 and dda_en = 1, so the core integrators capture their ICs on that edge.
  - step_count is cleared to 0 and the prescaler to 0.
  - Next state: RUN.
  - A stop in INIT → IDLE; the IC load still happens.
- RUN:
  - dda_rst = 0.
  - dda_en = 1 in the cycles where presc == div_q. In such a cycle, presc wraps to 0 and step_count increments (modular, wraps at 2^STEP_W).
  - Otherwise presc increments.
  - div_q = 0 gives dda_en high every cycle; div_q = D gives one pulse every D+1 cycles.
  - stop → IDLE next cycle; dda_en is 0 from that cycle on. step_count holds its value.
  - load and run are ignored.
- Latency:
  - run accepted at edge k: dda_rst and dda_en high in cycle k+1.
  - First RUN pulse in cycle k+2+div_q.
- Configuration words are only modified in LOAD, so they are stable throughout RUN.
- Reset mid-LOAD or mid-RUN: immediate return to the reset values above.

Decomposition:
- Shared package holds:
  - State encoding (IDLE, LOAD, INIT, RUN).
  - Word index constants (IDX_ICX…IDX_DT).
  - NUM_WORDS = 7.
  - Byte-count constant NUM_WORDS·N/8.
  - Byte-counter width as clog2(NUM_WORDS·N/8 + 1).
- One natural sub-module: dda_step_prescaler. It holds div_q, the presc counter, the dda_en strobe generation and step_count.
- The FSM and byte shifter stay in the top block.

Test Plan:
- Reset mid-RUN (div=3, after 5 steps) → all outputs return to 0 and state is IDLE. With the same stream loaded again but no new run, dda_en stays 0.
- Full load then run:
  - Stimulus: load, then 14 bytes 40 00 | 00 00 | 00 00 | 6A 00 | 4C 00 | 6A 00 | 10 00. Then run with div=0.
  - Expected: icx=0x4000, icy=icz=0, sigma=0x6A00, beta=0x4C00, rho=0x6A00, dt=0x1000. cfg_valid rises in the cycle after the 14th byte.
  - INIT cycle shows dda_rst=dda_en=1.
  - In RUN, dda_en is high every cycle; step_count=10 after 10 RUN cycles.
- Prescale: div=4 → dda_en pulses exactly every 5 cycles; first pulse 4 cycles after RUN entry; step_count=3 after 15 RUN cycles.
- Abort: load, 5 bytes, stop → cfg_valid=0; a later run is ignored (busy stays 0, dda_en stays 0).
- Priority and ignore rules:
  - load, run and stop in the same cycle in IDLE → stays IDLE.
  - load and run in the same cycle → LOAD.
  - data_valid bytes in IDLE → no word changes.
- Wrap: STEP_W overridden to 4, div=0, 17 RUN cycles → step_count=1. Then stop → dda_en=0 next cycle and step_count holds at 1.
